// File: rtl/sky130_gpio_in_cond_if.sv
// sky130_gpio_in_cond_if: pad-input conditioning signals between user logic and the conditioner
interface sky130_gpio_in_cond_if #(parameter int DB_W = 8);
    logic            gpio_in;
    logic            en;
    logic [DB_W-1:0] db_len;
    logic [1:0]      irq_mode;
    logic            irq_clear;
    logic            io_in;
    logic            rise;
    logic            fall;
    logic            irq_pending;
    modport master (
        output gpio_in, en, db_len, irq_mode, irq_clear,
        input  io_in, rise, fall, irq_pending
    );
    modport slave (
        input  gpio_in, en, db_len, irq_mode, irq_clear,
        output io_in, rise, fall, irq_pending
    );
endinterface

// File: rtl/sky130_gpio_in_cond.sv
// sky130_gpio_in_cond: synchronizer, debounce filter, edge strobes and sticky interrupt for one pad input
module sky130_gpio_in_cond #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_W        = 8,
    parameter logic RESET_VAL   = 1'b0
) (
    input logic                 clk,
    input logic                 rst_n,
    sky130_gpio_in_cond_if.slave bus
);
    typedef enum logic {IDLE, QUAL} state_t;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    logic [DB_W-1:0]        cnt;
    logic                   io_q, rise_q, fall_q, irq_q;
    assign s = sync[SYNC_STAGES-1];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= {SYNC_STAGES{RESET_VAL}};
        else sync <= {sync[SYNC_STAGES-2:0], bus.gpio_in};
    // cnt counts edges already seen with s != io_in; compare is against the live db_len
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            io_q   <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            irq_q  <= (rise_q & bus.irq_mode[0]) | (fall_q & bus.irq_mode[1]) | (irq_q & ~bus.irq_clear);
            if (!bus.en || s == io_q) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (state == IDLE && bus.db_len != '0) begin
                state <= QUAL;
                cnt   <= DB_W'(1);
            end else if (state == QUAL && cnt < bus.db_len) begin
                cnt <= cnt + DB_W'(1);
            end else begin
                io_q   <= s;
                rise_q <= s;
                fall_q <= ~s;
                state  <= IDLE;
                cnt    <= '0;
            end
        end
    assign bus.io_in       = io_q;
    assign bus.rise        = rise_q;
    assign bus.fall        = fall_q;
    assign bus.irq_pending = irq_q;
endmodule

// File: tb/tb_sky130_gpio_in_cond.sv
// tb_sky130_gpio_in_cond: directed and random checks against a run-length reference model
module tb_sky130_gpio_in_cond;
    localparam int SYNC = 2;
    localparam int DB_W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int total = 0;
    int bad = 0;
    int n_rise = 0;
    int n_fall = 0;
    int n;
    sky130_gpio_in_cond_if #(.DB_W(DB_W)) bus ();
    sky130_gpio_in_cond #(.SYNC_STAGES(SYNC), .DB_W(DB_W), .RESET_VAL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    // Model: a pad-sample delay line, and the number of consecutive edges the synchronized level has disagreed with io_in
    logic [SYNC-1:0] m_sync;
    logic m_io, m_rise, m_fall, m_irq;
    int run;
    task automatic model_reset();
        m_sync = '0;
        m_io = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_irq = 1'b0;
        run = 0;
    endtask
    task automatic chk(string tag, logic obs, logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask
    task automatic chk_int(string tag, int obs, int exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        logic s, nr, nf, ni;
        s  = m_sync[SYNC-1];
        ni = (m_rise & bus.irq_mode[0]) | (m_fall & bus.irq_mode[1]) | (m_irq & ~bus.irq_clear);
        nr = 1'b0;
        nf = 1'b0;
        if (bus.en && s != m_io) begin
            if (run >= int'(bus.db_len)) begin
                m_io = s;
                nr = s;
                nf = ~s;
                run = 0;
            end else run++;
        end else run = 0;
        m_sync = {m_sync[SYNC-2:0], bus.gpio_in};
        m_rise = nr;
        m_fall = nf;
        m_irq = ni;
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        chk("io_in", bus.io_in, m_io);
        chk("rise", bus.rise, m_rise);
        chk("fall", bus.fall, m_fall);
        chk("irq_pending", bus.irq_pending, m_irq);
        chk("no_both", bus.rise & bus.fall, 1'b0);
        n_rise += int'(bus.rise);
        n_fall += int'(bus.fall);
    endtask
    task automatic ticks(int k);
        for (int i = 0; i < k; i++) tick();
    endtask
    initial begin
        bus.gpio_in = 1'b0;
        bus.en = 1'b1;
        bus.db_len = '0;
        bus.irq_mode = 2'b00;
        bus.irq_clear = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_io", bus.io_in, 1'b0);
        chk("rst_rise", bus.rise, 1'b0);
        chk("rst_fall", bus.fall, 1'b0);
        chk("rst_irq", bus.irq_pending, 1'b0);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
        // N=0: three edges from pad to io_in
        bus.gpio_in = 1'b1;
        n = 0;
        while (bus.io_in === 1'b0 && n < 20) begin tick(); n++; end
        chk_int("n0_latency", n, 3);
        chk("n0_rise", bus.rise, 1'b1);
        chk("n0_fall", bus.fall, 1'b0);
        tick();
        chk("n0_rise_once", bus.rise, 1'b0);
        // N=4: held high, then a 4-cycle pulse that must be rejected
        bus.gpio_in = 1'b0;
        ticks(5);
        bus.db_len = 8'd4;
        bus.gpio_in = 1'b1;
        n = 0;
        while (bus.io_in === 1'b0 && n < 20) begin tick(); n++; end
        chk_int("n4_latency", n, 7);
        ticks(3);
        bus.gpio_in = 1'b0;
        ticks(12);
        chk("n4_low", bus.io_in, 1'b0);
        n_rise = 0;
        n_fall = 0;
        bus.gpio_in = 1'b1;
        ticks(4);
        bus.gpio_in = 1'b0;
        ticks(12);
        chk_int("n4_pulse_strobes", n_rise + n_fall, 0);
        chk("n4_pulse_io", bus.io_in, 1'b0);
        // N=3: toggling every cycle never qualifies
        bus.db_len = 8'd3;
        for (int i = 0; i < 20; i++) begin bus.gpio_in = ~bus.gpio_in; tick(); end
        bus.gpio_in = 1'b0;
        ticks(10);
        chk_int("toggle_strobes", n_rise + n_fall, 0);
        // interrupt on fall only; set beats a simultaneous clear
        bus.db_len = 8'd0;
        bus.irq_mode = 2'b10;
        bus.gpio_in = 1'b1;
        ticks(4);
        chk("irq_after_rise", bus.irq_pending, 1'b0);
        bus.gpio_in = 1'b0;
        ticks(3);
        chk("irq_fall_strobe", bus.fall, 1'b1);
        tick();
        chk("irq_after_fall", bus.irq_pending, 1'b1);
        bus.gpio_in = 1'b1;
        ticks(4);
        bus.gpio_in = 1'b0;
        ticks(3);
        bus.irq_clear = 1'b1;
        tick();
        bus.irq_clear = 1'b0;
        chk("irq_set_wins", bus.irq_pending, 1'b1);
        ticks(2);
        bus.irq_clear = 1'b1;
        tick();
        bus.irq_clear = 1'b0;
        chk("irq_cleared", bus.irq_pending, 1'b0);
        // N=200 lowered to 10 mid-qualify, then reset mid-qualify
        bus.irq_mode = 2'b00;
        bus.db_len = 8'd200;
        bus.gpio_in = 1'b1;
        ticks(52);
        chk("long_wait_io", bus.io_in, 1'b0);
        bus.db_len = 8'd10;
        tick();
        chk("lowered_len_io", bus.io_in, 1'b1);
        chk("lowered_len_rise", bus.rise, 1'b1);
        bus.db_len = 8'd200;
        bus.gpio_in = 1'b0;
        ticks(30);
        chk("pre_reset_io", bus.io_in, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midq_reset_io", bus.io_in, 1'b0);
        chk("midq_reset_fall", bus.fall, 1'b0);
        n_rise = 0;
        n_fall = 0;
        ticks(2);
        rst_n = 1'b1;
        ticks(5);
        chk_int("midq_reset_strobes", n_rise + n_fall, 0);
        // en=0 freezes io_in but keeps irq_pending
        bus.irq_mode = 2'b11;
        bus.db_len = 8'd0;
        bus.gpio_in = 1'b1;
        ticks(4);
        chk("en_irq_set", bus.irq_pending, 1'b1);
        bus.db_len = 8'd5;
        bus.en = 1'b0;
        bus.gpio_in = 1'b0;
        n_rise = 0;
        n_fall = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("en0_hold_io", bus.io_in, 1'b1);
            chk("en0_hold_irq", bus.irq_pending, 1'b1);
        end
        bus.en = 1'b1;
        n = 0;
        while (bus.io_in === 1'b1 && n < 20) begin tick(); n++; end
        chk_int("reenable_latency", n, 6);
        ticks(3);
        chk_int("reenable_fall", n_fall, 1);
        chk_int("reenable_rise", n_rise, 0);
        // random phase
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) bus.gpio_in = ~bus.gpio_in;
            if ($urandom_range(40) == 0) bus.db_len = DB_W'($urandom_range(5));
            if ($urandom_range(20) == 0) bus.irq_mode = 2'($urandom_range(3));
            bus.irq_clear = ($urandom_range(15) == 0);
            bus.en = ($urandom_range(9) != 0);
            if ($urandom_range(300) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                chk("rand_reset_io", bus.io_in, 1'b0);
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
